// File: rtl/traffic_timer_if.sv
// Request/response bundle between the light-sequencing FSM (master) and
// traffic_timer (slave).
interface traffic_timer_if;
  // Strobes only, no backpressure: reprogram and start_timer are one-cycle
  // requests taken on any rising edge they are high (the timer is always
  // ready); expired and one_hz_tick are one-cycle pulses the master must
  // consume in the cycle they are high.
  logic       reprogram;
  logic [1:0] time_param_selector;
  logic [3:0] time_value;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz_tick;
  logic       state_dbg;

  modport master (
    output reprogram, time_param_selector, time_value, start_timer, interval_sel,
    input  expired, busy, remaining, one_hz_tick, state_dbg
  );

  modport slave (
    input  reprogram, time_param_selector, time_value, start_timer, interval_sel,
    output expired, busy, remaining, one_hz_tick, state_dbg
  );
endinterface

// File: rtl/traffic_timer.sv
// Programmable interval timer for the traffic-light FSM: three interval
// registers, 1 Hz divider, countdown FSM. TRAFFIC_TIMER_FAST_SIM_EN bypasses the divider.
module traffic_timer #(
  parameter int CLKS_PER_SEC = 16,
  parameter int T_BASE_DEF   = 6,
  parameter int T_EXT_DEF    = 3,
  parameter int T_YEL_DEF    = 2
) (
  input  logic            clk,
  input  logic            reset,
  traffic_timer_if.slave  tif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state;
  logic [3:0] t_base;
  logic [3:0] t_ext;
  logic [3:0] t_yel;
  logic [3:0] remaining_q;
  logic       expired_q;
  logic       tick_q;
  logic [3:0] sel_value;
  logic [3:0] wr_value;
  logic       tick_now;
  logic       last_sec;

  // Reserved select loads the base interval.
  always_comb begin
    sel_value = t_base;
    case (tif.interval_sel)
      2'b01:   sel_value = t_ext;
      2'b10:   sel_value = t_yel;
      default: sel_value = t_base;
    endcase
  end

  assign wr_value = (tif.time_value == 4'd0) ? 4'd1 : tif.time_value;
  assign last_sec = (remaining_q <= 4'd1);

`ifdef TRAFFIC_TIMER_FAST_SIM_EN
  assign tick_now = (state == RUN);
`else
  localparam int DIV_W = $clog2(CLKS_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_SEC - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tif.start_timer || div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_now = (div_cnt == DIV_MAX);
`endif

  // Writes land in the register file only; a running countdown keeps its copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_base <= 4'(T_BASE_DEF);
      t_ext  <= 4'(T_EXT_DEF);
      t_yel  <= 4'(T_YEL_DEF);
    end else if (tif.reprogram) begin
      case (tif.time_param_selector)
        2'b00:   t_base <= wr_value;
        2'b01:   t_ext  <= wr_value;
        2'b10:   t_yel  <= wr_value;
        default: ;
      endcase
    end
  end

  // Countdown FSM; start_timer has priority over a coincident final tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remaining_q <= 4'd0;
      expired_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      expired_q <= 1'b0;
`ifdef TRAFFIC_TIMER_FAST_SIM_EN
      tick_q <= tif.start_timer || (state == RUN && !last_sec);
`else
      tick_q <= tick_now && !tif.start_timer;
`endif
      if (tif.start_timer) begin
        state       <= RUN;
        remaining_q <= sel_value;
      end else if (state == RUN && tick_now) begin
        if (last_sec) begin
          state       <= IDLE;
          remaining_q <= 4'd0;
          expired_q   <= 1'b1;
        end else begin
          remaining_q <= remaining_q - 4'd1;
        end
      end
    end
  end

  assign tif.expired     = expired_q;
  assign tif.busy        = (state == RUN);
  assign tif.remaining   = remaining_q;
  assign tif.one_hz_tick = tick_q;
  assign tif.state_dbg   = state;

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer: vector table of write/start/expected-length
// records plus hand sequences for restart, coincident start, and async reset.
module tb_traffic_timer;
  localparam int CPS = 16;
`ifdef TRAFFIC_TIMER_FAST_SIM_EN
  localparam int SEC  = 1;
  localparam bit FAST = 1'b1;
`else
  localparam int SEC  = CPS;
  localparam bit FAST = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  traffic_timer_if tif();

  traffic_timer #(
    .CLKS_PER_SEC(CPS),
    .T_BASE_DEF  (6),
    .T_EXT_DEF   (3),
    .T_YEL_DEF   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tif  (tif.slave)
  );

  typedef struct {
    bit         wr;
    logic [1:0] wsel;
    logic [3:0] wval;
    logic [1:0] ssel;
    int         exp_s;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // {expired, busy, remaining, one_hz_tick}
  function automatic logic [31:0] obs();
    return {25'b0, tif.expired, tif.busy, tif.remaining, tif.one_hz_tick};
  endfunction

  function automatic logic [31:0] exp_obs(bit e, bit b, int r, bit t);
    return {25'b0, e, b, 4'(r), t};
  endfunction

  function automatic bit exp_tick(int c, int n);
    if (FAST) return (c < n);
    return (c > 0) && (c % SEC == 0);
  endfunction

  // driver tasks
  task automatic do_write(input logic [1:0] sel, input logic [3:0] val);
    tif.reprogram = 1'b1;
    tif.time_param_selector = sel;
    tif.time_value = val;
    @(negedge clk);
    tif.reprogram = 1'b0;
  endtask

  task automatic start_only(input logic [1:0] sel);
    tif.interval_sel = sel;
    tif.start_timer = 1'b1;
    @(negedge clk);
    tif.start_timer = 1'b0;
  endtask

  task automatic run_interval(input logic [1:0] sel, input int n, input bit wr,
                              input logic [1:0] wsel, input logic [3:0] wval);
    int c;
    bit seen;
    exp_q.push_back(16'(n * SEC));
    tif.interval_sel = sel;
    tif.start_timer = 1'b1;
    tif.reprogram = wr;
    tif.time_param_selector = wsel;
    tif.time_value = wval;
    @(negedge clk);
    tif.start_timer = 1'b0;
    tif.reprogram = 1'b0;
    check("start", obs(), exp_obs(1'b0, 1'b1, n, FAST));
    c = 0;
    seen = 1'b0;
    while (!seen && c < 300) begin
      @(negedge clk);
      c++;
      if (tif.expired === 1'b1) seen = 1'b1;
      else check("count", obs(), exp_obs(1'b0, 1'b1, n - c / SEC, exp_tick(c, n)));
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL expire_timeout: no expired within %0d cycles, expected after %0d", c, n * SEC);
      void'(exp_q.pop_front());
    end else begin
      check("expire", obs(), exp_obs(1'b1, 1'b0, 0, exp_tick(c, n)));
      check("latency", 32'(c), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    check("post_expire", {31'b0, tif.expired}, 32'd0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tif.expired === 1'b1) hit = 1'b1;
    end
    check(name, {31'b0, hit}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 4'd0,  2'b00, 6};
    vecs[1]  = '{1'b0, 2'b00, 4'd0,  2'b01, 3};
    vecs[2]  = '{1'b0, 2'b00, 4'd0,  2'b10, 2};
    vecs[3]  = '{1'b0, 2'b00, 4'd0,  2'b11, 6};
    vecs[4]  = '{1'b1, 2'b11, 4'd9,  2'b00, 6};
    vecs[5]  = '{1'b0, 2'b00, 4'd0,  2'b01, 3};
    vecs[6]  = '{1'b0, 2'b00, 4'd0,  2'b10, 2};
    vecs[7]  = '{1'b1, 2'b10, 4'd5,  2'b10, 5};
    vecs[8]  = '{1'b1, 2'b01, 4'd0,  2'b01, 1};
    vecs[9]  = '{1'b1, 2'b00, 4'd15, 2'b00, 15};
    vecs[10] = '{1'b1, 2'b00, 4'd6,  2'b00, 6};

    tif.reprogram = 1'b0;
    tif.time_param_selector = 2'b00;
    tif.time_value = 4'd0;
    tif.start_timer = 1'b0;
    tif.interval_sel = 2'b00;

    repeat (3) @(negedge clk);
    check("reset_state", obs(), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("after_release", obs(), 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) do_write(vecs[i].wsel, vecs[i].wval);
      run_interval(vecs[i].ssel, vecs[i].exp_s, 1'b0, 2'b00, 4'd0);
      repeat (2) @(negedge clk);
    end

    // Restart 20 cycles into a 3 s countdown with the 2 s yellow interval.
    do_write(2'b01, 4'd3);
    do_write(2'b10, 4'd2);
    start_only(2'b01);
    expect_quiet("restart_pre", 19);
    run_interval(2'b10, 2, 1'b0, 2'b00, 4'd0);
    expect_quiet("restart_after", 40);

    // Start on the very edge the final tick would land on.
    start_only(2'b10);
    expect_quiet("coincide_pre", 2 * SEC - 1);
    run_interval(2'b01, 3, 1'b0, 2'b00, 4'd0);

    // Write and start the same register on one edge: old value is loaded.
    run_interval(2'b10, 2, 1'b1, 2'b10, 4'd7);
    run_interval(2'b10, 7, 1'b0, 2'b00, 4'd0);

    // Async reset 40 cycles into a base countdown.
    do_write(2'b00, 4'd9);
    start_only(2'b00);
    repeat (39) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", obs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_quiet("reset_no_expire", 160);
    run_interval(2'b00, 6, 1'b0, 2'b00, 4'd0);
    run_interval(2'b10, 2, 1'b0, 2'b00, 4'd0);
    run_interval(2'b01, 3, 1'b0, 2'b00, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/traffic_timer.md
# traffic_timer

Programmable interval timer feeding the traffic-light controller FSM. Holds the three reprogrammable durations (base, extended, yellow), divides the system clock down to a one-second tick, and counts down whichever interval the FSM requests, pulsing `expired` when it elapses. Sits directly upstream of the light-sequencing FSM, which drives `start_timer`/`interval_sel` and consumes `expired`.

## Interface
Parameters:
- `CLKS_PER_SEC`, 16, clock cycles per one-second tick (≥2)
- `T_BASE_DEF`, 6, reset value of base interval (seconds, 1..15)
- `T_EXT_DEF`, 3, reset value of extended interval
- `T_YEL_DEF`, 2, reset value of yellow interval

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `reprogram`  in  1  write strobe for interval registers
- `time_param_selector`  in  2  register select for write: 00 base, 01 extended, 10 yellow, 11 reserved
- `time_value`  in  4  new interval in seconds
- `start_timer`  in  1  load countdown from register `interval_sel` and run
- `interval_sel`  in  2  interval to load (same encoding as selector)
- `expired`  out  1  one-cycle pulse, interval elapsed
- `busy`  out  1  countdown running
- `remaining`  out  4  seconds left in current countdown
- `one_hz_tick`  out  1  one-cycle divider pulse

## Operation
- Reset (reset=0, async): registers ← T_BASE_DEF/T_EXT_DEF/T_YEL_DEF; divider count 0; state IDLE; `expired`=0, `busy`=0, `remaining`=0, `one_hz_tick`=0.
- Write: `reprogram`=1 at an edge stores `time_value` into selected register; `time_value`=0 stored as 1; selector 11 ignored. Writes never affect a running countdown.
- FSM states: IDLE, RUN.
  - IDLE: `start_timer` → load `remaining` with selected register (selector 11 loads base), clear divider, → RUN.
  - RUN: on tick, `remaining` decrements; when `remaining`=1 at tick → `remaining`=0, `expired`=1 for one cycle, → IDLE.
  - RUN + `start_timer`: reload and clear divider (restart); no `expired` for aborted interval.
- Divider: free-running 0..CLKS_PER_SEC-1 counter, wraps to 0; `one_hz_tick` registered high for the cycle after count reaches CLKS_PER_SEC-1. Cleared by every `start_timer`.
- `busy` = (state == RUN).

## Timing
- `start_timer` sampled at edge k: `busy`=1 and `remaining`=N from edge k.
- Tick i lands at edge k+i·CLKS_PER_SEC; `expired` high exactly for cycle following edge k+N·CLKS_PER_SEC, `busy` low same edge.
- Simultaneous `start_timer` with final tick: start wins, reload, no `expired`.
- Simultaneous `reprogram` and `start_timer` on same register: countdown loads old value; new value used from next start.
- `reset` asserted mid-count: immediate return to reset state, no `expired`.
- All outputs registered; no combinational input→output path.

## Configuration
- `TRAFFIC_TIMER_FAST_SIM_EN` defined: divider bypassed, `one_hz_tick` high every cycle while RUN (interval N expires N cycles after start). Undefined: normal CLKS_PER_SEC division. Register, write, and FSM behaviour identical in both.

## Test plan
- Reset release, `start_timer` with sel=00, CLKS_PER_SEC=16 → `expired` pulse 96 cycles after start edge, `remaining` 6→0 stepping every 16 cycles.
- `reprogram`, selector=10, value=5; start sel=10 → `expired` after 80 cycles; value=0 write then start → expires after 16 cycles.
- Start sel=01 (3 s), restart with sel=10 at cycle 20 → single `expired` 32 cycles after restart, none at cycle 48.
- Write selector=11 value=9 → all three registers unchanged (starts still give 6/3/2 s).
- `reset` low at cycle 40 of a base countdown → outputs zero immediately, no `expired` afterwards.
- `TRAFFIC_TIMER_FAST_SIM_EN` defined, start sel=00 → `expired` 6 cycles after start.
